// File: rtl/sum_share_sched.sv
// sum_share_sched: two requesters share one accumulate adder, one operand per cycle.
// Optional busy-cycle counter port when SUM_SHARE_SCHED_PERF_EN is defined.
module sum_share_sched #(
  parameter int WIDTH = 8,
  parameter int N_OPS = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       req_valid,
  input  logic [N_OPS*WIDTH-1:0]           req_ops0,
  input  logic [N_OPS*WIDTH-1:0]           req_ops1,
  output logic [1:0]                       req_ready,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [WIDTH+$clog2(N_OPS+1)-1:0] res_sum,
  output logic                             res_id,
  output logic                             busy
`ifdef SUM_SHARE_SCHED_PERF_EN
  ,
  output logic [31:0]                      perf_busy_cnt
`endif
);

  localparam int SW = WIDTH + $clog2(N_OPS + 1);
  localparam int CW = (N_OPS > 1) ? $clog2(N_OPS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t                        state;
  state_t                        state_nxt;
  logic                          rr_ptr;
  logic [SW-1:0]                 acc;
  logic [CW-1:0]                 cnt;
  logic [N_OPS-1:0][WIDTH-1:0]   ops;
  logic                          gnt_fire;
  logic                          gnt_id;
  logic [N_OPS*WIDTH-1:0]        sel_ops;

  // The accumulator doubles as the result register; it is only shown in DONE.
  assign res_sum = acc;
  assign sel_ops = gnt_id ? req_ops1 : req_ops0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration, next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    gnt_fire  = 1'b0;
    gnt_id    = rr_ptr;
    res_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (|req_valid) begin
          gnt_fire  = 1'b1;
          gnt_id    = (&req_valid) ? rr_ptr : req_valid[1];
          req_ready = gnt_id ? 2'b10 : 2'b01;
          state_nxt = (N_OPS == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (cnt == CW'(N_OPS - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at grant, then one zero-extended add per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      res_id <= 1'b0;
      ops    <= '0;
    end else if (gnt_fire) begin
      ops    <= sel_ops;
      acc    <= SW'(sel_ops[WIDTH-1:0]);
      cnt    <= CW'(1);
      res_id <= gnt_id;
      rr_ptr <= ~gnt_id;
    end else if (state == ACCUM) begin
      acc <= acc + SW'(ops[cnt]);
      cnt <= cnt + CW'(1);
    end
  end

`ifdef SUM_SHARE_SCHED_PERF_EN
  // Saturating count of busy cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cnt <= '0;
    end else if (busy && (perf_busy_cnt != 32'hFFFF_FFFF)) begin
      perf_busy_cnt <= perf_busy_cnt + 32'd1;
    end
  end
`endif

endmodule
